serial_word_rx: RTL and testbench
=================================

# serial_word_rx

Serial word receiver that sits directly downstream of the 4-bit universal shift register. It consumes the single-bit serial stream the shift register emits in its shift-right (LSB-first) or shift-left (MSB-first) modes. It frames that stream (start bit, data, optional even parity, stop bit), reassembles a parallel word, checks it, and presents it to the consumer through a one-entry valid/ready output register. Overrun, parity and framing errors are flagged.

## Interface
Parameters:
- WIDTH, 4, data bits per frame (2–16)
- PARITY_EN, 1, 1 = one even-parity bit follows the data; 0 = no parity bit

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- bit_in  input  1  serial data bit
- bit_valid  input  1  bit_in is sampled only in cycles where this is 1
- msb_first  input  1  bit order of the data field, sampled when the start bit is accepted, held for the frame
- word_out  output  WIDTH  assembled data word, stable while word_valid=1
- word_valid  output  1  word_out holds an unconsumed word
- word_ready  input  1  consumer accepts word_out when word_valid & word_ready
- parity_err  output  1  one-cycle pulse: received parity bit wrong
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0
- overrun  output  1  sticky: a good frame completed while word_valid=1 and was not accepted
- clr_overrun  input  1  synchronous clear of overrun

## Operation
- Reset (rst=0, asynchronous): FSM to IDLE, bit counter and shift register cleared. word_out=0, word_valid=0, parity_err=0, frame_err=0, overrun=0.
- FSM states, advancing only on cycles with bit_valid=1:
  - IDLE: bit_in=0 is the start bit, so latch msb_first and go to DATA with count=0. bit_in=1 stays in IDLE (line idle).
  - DATA: shift bit_in into the assembly register and increment count. LSB-first fills bit[count]. MSB-first shifts left and inserts at bit 0. After WIDTH bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY: compare bit_in with the XOR of the data bits. A mismatch sets an internal bad flag. Go to STOP.
  - STOP: bit_in=1 means a good stop. bit_in=0 pulses frame_err and discards the word. Both go to IDLE.
- A frame with a bad parity bit and a good stop pulses parity_err and discards the word. A frame with both errors pulses both flags, and the word is discarded.
- Good frame completion:
  - word_valid=0, or word_valid=1 with word_ready=1 in the same cycle: load word_out and set word_valid=1.
  - word_valid=1 with word_ready=0: the new word is dropped, word_out is unchanged, and overrun is set.
- Handshake: when word_valid & word_ready and no new word loads that cycle, word_valid clears next edge. word_out holds its last value after consumption.
- overrun clears only on clr_overrun=1 or reset. Set and clear in the same cycle resolves to set.
- bit_valid=0 cycles freeze the FSM, counter and assembly register, with no timeout.

## Timing
- Sampling on rising clk edge when bit_valid=1. Bits need not be on consecutive cycles.
- Latency: word_valid rises on the edge at which the stop bit is sampled, so it is visible the cycle after the stop-bit cycle.
- parity_err and frame_err are high for exactly one cycle, the cycle after the stop-bit sample.
- Frame length is 1 + WIDTH + PARITY_EN + 1 valid bits. With the defaults that is 7.
- Back-to-back frames: the start bit of the next frame may be presented in the cycle immediately after the stop bit, with no idle bit needed.
- word_out never changes while word_valid=1 unless a handshake occurs in that cycle.
- Reset asserted mid-frame: the partial frame is lost immediately with no error pulse, and reception restarts from IDLE after release.
- msb_first changes mid-frame have no effect on the current frame.

## Test plan
- Reset: hold rst=0 for 15 ns with clk toggling -> all outputs 0. Release -> FSM in IDLE, and bit_in=1 with bit_valid=1 for 5 cycles gives no word_valid.
- LSB-first good frame: WIDTH=4, PARITY_EN=1, word_ready=1, msb_first=0, bits 0,1,1,0,1,1,1 -> word_out=4'hB, word_valid high one cycle after the stop bit, no error pulses.
- MSB-first with gaps: msb_first=1, bits 0,1,0,1,1,1,1 with bit_valid low on alternate cycles -> word_out=4'hB.
- Errors:
  - Frame 0,1,1,0,1,0,1 (bad parity) -> parity_err one-cycle pulse, word_valid stays 0.
  - Frame 0,1,1,0,1,1,0 (bad stop) -> frame_err pulse, no word.
- Overrun and handshake: word_ready=0, send 4'hB then 4'h3 (bits 0,1,1,0,0,0,1) -> word_out stays 4'hB and overrun=1. word_ready=1 for one cycle -> word_valid=0 next cycle. clr_overrun -> overrun=0.
- Reset mid-frame: assert rst after 3 data bits -> outputs return to 0 immediately. The next full frame 4'h5 (bits 0,1,0,1,0,0,1) is received correctly.

Source files
------------

// File: rtl/serial_word_rx.sv
// -----------------------------------------------------------------------------
// serial_word_rx
//
// Receives the single-bit stream produced by the upstream 4-bit universal shift
// register (LSB-first in shift-right mode, MSB-first in shift-left mode). It
// frames the stream as start bit (0), WIDTH data bits, an optional even-parity
// bit and a stop bit (1). It reassembles the data word and hands it to the
// consumer through a one-entry valid/ready output register.
//
// Parameters
//   WIDTH      data bits per frame (2..16)
//   PARITY_EN  1 = one even-parity bit follows the data, 0 = none
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   bit_in       serial data bit, sampled only when bit_valid=1
//   bit_valid    qualifies bit_in; 0 freezes the receiver
//   msb_first    data-field bit order, captured with the start bit
//   word_out     last accepted word, stable while word_valid=1
//   word_valid   word_out holds an unconsumed word
//   word_ready   consumer takes word_out when word_valid & word_ready
//   parity_err   one-cycle pulse after a stop bit when the parity was wrong
//   frame_err    one-cycle pulse after a stop bit that was sampled as 0
//   overrun      sticky: a good word was dropped because the register was full
//   clr_overrun  synchronous clear of overrun (a same-cycle set wins)
// -----------------------------------------------------------------------------
module serial_word_rx #(
   parameter int WIDTH     = 4,
   parameter int PARITY_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic             msb_first,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             parity_err,
   output logic             frame_err,
   output logic             overrun,
   input  logic             clr_overrun
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   // Framing state
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [WIDTH-1:0] asm_q,   asm_d;
   logic             msb_q,   msb_d;
   logic             bad_q,   bad_d;

   // Output register and status flags
   logic [WIDTH-1:0] word_q,  word_d;
   logic             valid_q, valid_d;
   logic             perr_q,  perr_d;
   logic             ferr_q,  ferr_d;
   logic             ovr_q,   ovr_d;

   logic             frame_good;
   logic             take;
   logic             ovr_set;

   // --------------------------------------------------------------------------
   // Frame reception
   // --------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      asm_d      = asm_q;
      msb_d      = msb_q;
      bad_d      = bad_q;
      perr_d     = 1'b0;
      ferr_d     = 1'b0;
      frame_good = 1'b0;

      if (bit_valid) begin
         case (state_q)
            S_IDLE: begin
               // A 0 on an idle line is the start bit; the bit order is
               // captured here so later msb_first changes cannot affect it.
               if (!bit_in) begin
                  state_d = S_DATA;
                  cnt_d   = '0;
                  asm_d   = '0;
                  msb_d   = msb_first;
                  bad_d   = 1'b0;
               end
            end

            S_DATA: begin
               if (msb_q) begin
                  asm_d = {asm_q[WIDTH-2:0], bit_in};
               end else begin
                  for (int i = 0; i < WIDTH; i++) begin
                     if (cnt_q == CNT_W'(i)) asm_d[i] = bit_in;
                  end
               end
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end
            end

            S_PARITY: begin
               // Even parity: the parity bit must equal the XOR of the data.
               bad_d   = bit_in ^ (^asm_q);
               state_d = S_STOP;
            end

            S_STOP: begin
               state_d    = S_IDLE;
               ferr_d     = ~bit_in;
               perr_d     = bad_q;
               frame_good = bit_in & ~bad_q;
            end

            default: state_d = S_IDLE;
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Output register / handshake
   // --------------------------------------------------------------------------
   always_comb begin
      word_d  = word_q;
      valid_d = valid_q;
      ovr_set = 1'b0;
      take    = valid_q & word_ready;

      if (frame_good) begin
         // A word being consumed this cycle frees the slot for the new one.
         if (!valid_q || word_ready) begin
            word_d  = asm_q;
            valid_d = 1'b1;
         end else begin
            ovr_set = 1'b1;
         end
      end else if (take) begin
         valid_d = 1'b0;
      end

      ovr_d = ovr_set | (ovr_q & ~clr_overrun);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         asm_q   <= '0;
         msb_q   <= 1'b0;
         bad_q   <= 1'b0;
         word_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         msb_q   <= msb_d;
         bad_q   <= bad_d;
         word_q  <= word_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign word_out   = word_q;
   assign word_valid = valid_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_word_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_word_rx
//
// Drives frames into serial_word_rx and compares every output, every cycle,
// against a frame-level reference model: the bench knows which frame it is
// sending, its data value and which of its bits is corrupted, and derives the
// expected word register, valid, error pulses and overrun from the receiver's
// behavioural rules.
// -----------------------------------------------------------------------------
module tb_serial_word_rx;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         bit_in = 1'b1;
   logic         bit_valid = 1'b0;
   logic         msb_first = 1'b0;
   logic         word_ready = 1'b0;
   logic         clr_overrun = 1'b0;
   logic [W-1:0] word_out;
   logic         word_valid;
   logic         parity_err;
   logic         frame_err;
   logic         overrun;

   always #5 clk = ~clk;

   serial_word_rx #(.WIDTH(W), .PARITY_EN(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .bit_in      (bit_in),
      .bit_valid   (bit_valid),
      .msb_first   (msb_first),
      .word_out    (word_out),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .parity_err  (parity_err),
      .frame_err   (frame_err),
      .overrun     (overrun),
      .clr_overrun (clr_overrun)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [W-1:0] exp_word  = '0;
   logic         exp_valid = 1'b0;
   logic         exp_ovr   = 1'b0;
   logic         exp_perr  = 1'b0;
   logic         exp_ferr  = 1'b0;

   // Consumer behaviour: 0 = never ready, 1 = always ready, 2 = random
   int rdy_mode  = 1;
   bit clr_en    = 1'b0;
   bit clr_force = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outs();
      check("word_valid", 32'(word_valid), 32'(exp_valid));
      check("word_out",   32'(word_out),   32'(exp_word));
      check("parity_err", 32'(parity_err), 32'(exp_perr));
      check("frame_err",  32'(frame_err),  32'(exp_ferr));
      check("overrun",    32'(overrun),    32'(exp_ovr));
   endtask

   // One clock cycle: apply inputs, advance the model, sample after the edge.
   // is_stop marks the stop-bit cycle of a frame whose data is 'data' and
   // whose parity/stop bits were corrupted according to pbad/sbad.
   task automatic cycle(input logic b, input logic v, input logic msb,
                        input bit is_stop, input bit pbad, input bit sbad,
                        input logic [W-1:0] data);
      logic rdy;
      logic clr;
      logic ovr_set;
      rdy = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
      clr = clr_force | (clr_en && ($urandom_range(0, 5) == 0));
      bit_in      = b;
      bit_valid   = v;
      msb_first   = msb;
      word_ready  = rdy;
      clr_overrun = clr;

      ovr_set  = 1'b0;
      exp_perr = v && is_stop && pbad;
      exp_ferr = v && is_stop && sbad;
      if (v && is_stop && !pbad && !sbad) begin
         if (!exp_valid || rdy) begin
            exp_word  = data;
            exp_valid = 1'b1;
         end else begin
            ovr_set = 1'b1;
         end
      end else if (exp_valid && rdy) begin
         exp_valid = 1'b0;
      end
      exp_ovr = ovr_set | (exp_ovr & ~clr);

      @(posedge clk);
      #1;
      check_outs();
   endtask

   task automatic idle(input int n, input logic b, input logic v);
      for (int i = 0; i < n; i++) cycle(b, v, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, '0);
   endtask

   // gap_mode: 0 = back-to-back bits, 1 = one idle cycle before every bit,
   // 2 = random 0..2 idle cycles before each bit
   task automatic send_frame(input logic [W-1:0] data, input bit msb, input bit pbad,
                             input bit sbad, input int gap_mode);
      logic bits[$];
      int   ng;
      bits = {};
      bits.push_back(1'b0);
      for (int i = 0; i < W; i++) bits.push_back(msb ? data[W-1-i] : data[i]);
      bits.push_back((^data) ^ pbad);
      bits.push_back(~sbad);
      for (int k = 0; k < bits.size(); k++) begin
         ng = (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
         for (int g = 0; g < ng; g++)
            cycle(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, '0);
         cycle(bits[k], 1'b1, (k == 0) ? 1'(msb) : 1'($urandom_range(0, 1)),
               k == bits.size() - 1, pbad, sbad, data);
      end
   endtask

   task automatic zero_model();
      exp_word  = '0;
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
      exp_perr  = 1'b0;
      exp_ferr  = 1'b0;
   endtask

   initial begin
      // Reset held across two edges: everything must read 0
      repeat (2) @(posedge clk);
      #1;
      check_outs();
      rst = 1'b1;

      // Idle line: no word may appear
      idle(5, 1'b1, 1'b1);

      // LSB-first 4'hB, consumer ready
      rdy_mode = 1;
      send_frame(4'hB, 1'b0, 1'b0, 1'b0, 0);
      check("lsb_word", 32'(word_out), 32'hB);
      idle(2, 1'b1, 1'b1);

      // MSB-first 4'hB with bit_valid low on alternate cycles
      send_frame(4'hB, 1'b1, 1'b0, 1'b0, 1);
      check("msb_word", 32'(word_out), 32'hB);
      idle(2, 1'b1, 1'b1);

      // Bad parity, then bad stop, then both
      send_frame(4'hB, 1'b0, 1'b1, 1'b0, 0);
      idle(1, 1'b1, 1'b1);
      send_frame(4'hB, 1'b0, 1'b0, 1'b1, 0);
      idle(1, 1'b1, 1'b1);
      send_frame(4'h6, 1'b1, 1'b1, 1'b1, 0);
      idle(1, 1'b1, 1'b1);

      // Overrun: consumer stalled, two good frames back to back
      rdy_mode = 0;
      send_frame(4'hB, 1'b0, 1'b0, 1'b0, 0);
      send_frame(4'h3, 1'b0, 1'b0, 1'b0, 0);
      check("ovr_word", 32'(word_out), 32'hB);
      check("ovr_flag", 32'(overrun), 32'h1);
      rdy_mode = 1;
      idle(1, 1'b1, 1'b0);
      check("ovr_consumed", 32'(word_valid), 32'h0);
      clr_force = 1'b1;
      idle(1, 1'b1, 1'b0);
      clr_force = 1'b0;
      check("ovr_cleared", 32'(overrun), 32'h0);

      // Reset mid-frame after three data bits
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      bit_valid = 1'b0;
      rst = 1'b0;
      zero_model();
      #1;
      check_outs();
      @(posedge clk);
      #1;
      rst = 1'b1;
      send_frame(4'h5, 1'b0, 1'b0, 1'b0, 0);
      check("post_reset_word", 32'(word_out), 32'h5);

      // Randomised traffic: random data, order, gaps, errors, consumer, clears
      rdy_mode = 2;
      clr_en   = 1'b1;
      for (int f = 0; f < 80; f++) begin
         send_frame(W'($urandom), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 2));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1'b1, 1'($urandom_range(0, 1)));
      end
      idle(4, 1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
